// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers the instruction memory word into
// the IF/ID output register with a valid/ready handshake. Optional: FETCH_PERF_EN.
module fetch_stage #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 18,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [PC_WIDTH-1:0]    out_pc_next
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            perf_fetch_cnt,
  output logic [15:0]            perf_stall_cnt
`endif
);

  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic                   valid_reg, valid_next;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
  logic [PC_WIDTH-1:0]    opc_reg, opc_next;
  logic [PC_WIDTH-1:0]    opc_inc_reg, opc_inc_next;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic                   load;
  logic                   do_fetch;

  assign pc_inc = pc_reg + 1'b1;
  assign load   = !valid_reg || out_ready;

  always_comb begin
    pc_next      = pc_reg;
    valid_next   = valid_reg;
    instr_next   = instr_reg;
    opc_next     = opc_reg;
    opc_inc_next = opc_inc_reg;
    do_fetch     = 1'b0;
    // A redirect flushes even while decode is stalling; the payload simply holds.
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      valid_next = 1'b0;
    end else if (load && fetch_en) begin
      do_fetch     = 1'b1;
      instr_next   = imem_data;
      opc_next     = pc_reg;
      opc_inc_next = pc_inc;
      valid_next   = 1'b1;
      pc_next      = pc_inc;
    end else if (load) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      valid_reg   <= 1'b0;
      instr_reg   <= '0;
      opc_reg     <= '0;
      opc_inc_reg <= '0;
    end else begin
      pc_reg      <= pc_next;
      valid_reg   <= valid_next;
      instr_reg   <= instr_next;
      opc_reg     <= opc_next;
      opc_inc_reg <= opc_inc_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign out_valid   = valid_reg;
  assign out_instr   = instr_reg;
  assign out_pc      = opc_reg;
  assign out_pc_next = opc_inc_reg;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_reg, stall_cnt_reg;
  logic        stall_cycle;

  assign stall_cycle = valid_reg && !out_ready && !redirect_valid;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (do_fetch && (fetch_cnt_reg != 16'hFFFF))
        fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
      if (stall_cycle && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`else
  logic unused_fetch;
  assign unused_fetch = do_fetch;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus feeds a queue of expected accepted
// instructions; a negedge monitor pops and compares every accepted transfer.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [7:0]  imem_addr;
  logic [17:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_instr;
  logic [7:0]  out_pc;
  logic [7:0]  out_pc_next;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Instruction memory contents: distinct word per address.
  function automatic logic [17:0] memf(input logic [7:0] a);
    logic [17:0] w;
    w = {2'b10, a, a} ^ 18'h05A5A;
    return w;
  endfunction

  always_comb imem_data = memf(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an instruction is delivered when valid & ready and no flush this cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready && !redirect_valid) begin
      logic [7:0] e;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL xfer: unexpected transfer out_pc=%0h with empty queue", out_pc);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e || out_instr !== memf(e) || out_pc_next !== 8'(e + 8'd1)) begin
          mismatched++;
          $display("FAIL xfer: got pc=%0h instr=%0h next=%0h expected pc=%0h instr=%0h next=%0h",
                   out_pc, out_instr, out_pc_next, e, memf(e), 8'(e + 8'd1));
        end else
          $display("ok   xfer: pc=%0h instr=%0h", out_pc, out_instr);
      end
    end
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_pc_next", 32'(out_pc_next), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Streaming from reset: words 0..4 accepted, 5 gets stalled first.
    for (int i = 0; i < 5; i++) sb.push_back(8'(i));
    rst_n = 1'b1;
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", 32'(out_pc), 32'd0);
    chk("first_instr", 32'(out_instr), 32'(memf(8'd0)));
    tick(); tick();
    chk("third_pc", 32'(out_pc), 32'd2);
    tick(); tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(out_pc), 32'd5);
      chk("stall_instr", 32'(out_instr), 32'(memf(8'd5)));
      chk("stall_addr", 32'(imem_addr), 32'd6);
    end
    for (int i = 5; i < 27; i++) sb.push_back(8'(i));
    out_ready = 1'b1;
    tick();
    chk("resume_pc", 32'(out_pc), 32'd6);
    for (int i = 0; i < 21; i++) tick();
    chk("at27_pc", 32'(out_pc), 32'd27);

    // Flush while stalled.
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 8'd22;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_addr", 32'(imem_addr), 32'd22);
    chk("flush_hold_pc", 32'(out_pc), 32'd27);
    redirect_valid = 1'b0; out_ready = 1'b1;
    sb.push_back(8'd22);
    tick();
    chk("tgt_pc", 32'(out_pc), 32'd22);
    chk("tgt_instr", 32'(out_instr), 32'(memf(8'd22)));
    tick();
    chk("tgt1_pc", 32'(out_pc), 32'd23);

    // Redirect to the top address; the presented word 23 is dropped.
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    tick();
    chk("ff_valid", 32'(out_valid), 32'd0);
    chk("ff_addr", 32'(imem_addr), 32'hFF);
    redirect_valid = 1'b0;
    sb.push_back(8'hFF); sb.push_back(8'h00);
    tick();
    chk("wrap_pc", 32'(out_pc), 32'hFF);
    chk("wrap_pc_next", 32'(out_pc_next), 32'h00);
    tick();
    chk("wrapped_pc", 32'(out_pc), 32'h00);

    // Bubbles with fetch disabled.
    fetch_en = 1'b0;
    tick();
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_addr", 32'(imem_addr), 32'd1);
    tick();
    chk("bubble2_valid", 32'(out_valid), 32'd0);
    chk("bubble2_addr", 32'(imem_addr), 32'd1);
    fetch_en = 1'b1; out_ready = 1'b0;
    tick();
    chk("refetch_pc", 32'(out_pc), 32'd1);
    chk("refetch_valid", 32'(out_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_pc", 32'(out_pc), 32'd0);

    // 10 fetches and 4 stall cycles after reset.
    for (int i = 0; i < 10; i++) sb.push_back(8'(i));
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("run_pc", 32'(out_pc), 32'd9);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    fetch_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", 32'(perf_fetch_cnt), 32'd10);
    chk("perf_stall", 32'(perf_stall_cnt), 32'd4);
`endif
    tick(); tick();
    chk("queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
